// File: rtl/pause_fade_if.sv
// Pixel/timing bundle between the pause stage, the fader and arcade_video.
interface pause_fade_if #(
  parameter int RW = 8,
  parameter int GW = 8,
  parameter int BW = 8
);
  logic [RW+GW+BW-1:0] rgb_in;
  logic                hs_in, vs_in, hb_in, vb_in;
  logic [RW+GW+BW-1:0] rgb_out;
  logic                hs_out, vs_out, hb_out, vb_out;

  modport master (
    output rgb_in, hs_in, vs_in, hb_in, vb_in,
    input  rgb_out, hs_out, vs_out, hb_out, vb_out
  );

  modport slave (
    input  rgb_in, hs_in, vs_in, hb_in, vb_in,
    output rgb_out, hs_out, vs_out, hb_out, vb_out
  );
endinterface

// File: rtl/pause_fade.sv
// Pause dimmer: fades brightness toward a target one step per STEP_FRAMES
// frames and scales the pixel stream through a 2-stage ce_pix pipeline.
module pause_fade #(
  parameter int RW          = 8,
  parameter int GW          = 8,
  parameter int BW          = 8,
  parameter int STEP_FRAMES = 4,
  parameter int MIN_LEVEL   = 8
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ce_pix,
  input  logic              dim_request,
  pause_fade_if.slave       vid,
  output logic [4:0]        level,
  output logic              fading
);
  localparam int PW = RW + GW + BW;

  typedef enum logic [1:0] {BRIGHT, FADE_OUT, DIM, FADE_IN} state_t;

  state_t        state_q, state_d;
  logic [4:0]    level_q, level_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          vb_prev_q, vb_prev_d;
  logic [PW-1:0] s1_rgb_q, s1_rgb_d, s2_rgb_q, s2_rgb_d;
  logic [3:0]    s1_sync_q, s1_sync_d, s2_sync_q, s2_sync_d;
  logic [4:0]    s1_lvl_q, s1_lvl_d;

  logic [4:0]    target;
  logic          tick, step;
  logic [RW+4:0] r_prod;
  logic [GW+4:0] g_prod;
  logic [BW+4:0] b_prod;

  always_comb begin
    target    = dim_request ? 5'(MIN_LEVEL) : 5'd16;
    tick      = ce_pix & vid.vb_in & ~vb_prev_q;
    step      = tick && (cnt_q == 8'(STEP_FRAMES - 1));
    state_d   = state_q;
    level_d   = level_q;
    cnt_d     = cnt_q;
    vb_prev_d = ce_pix ? vid.vb_in : vb_prev_q;

    case (state_q)
      BRIGHT: begin
        cnt_d = '0;
        if (dim_request) state_d = FADE_OUT;
      end
      FADE_OUT: begin
        // a reversal wins over a tick landing in the same cycle
        if (!dim_request) begin
          state_d = FADE_IN;
          cnt_d   = '0;
        end else if (step) begin
          cnt_d = '0;
          if (level_q > target) level_d = level_q - 5'd1;
          if (level_d <= target) state_d = DIM;
        end else if (tick) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      FADE_IN: begin
        if (dim_request) begin
          state_d = FADE_OUT;
          cnt_d   = '0;
        end else if (step) begin
          cnt_d = '0;
          if (level_q < 5'd16) level_d = level_q + 5'd1;
          if (level_d >= 5'd16) state_d = BRIGHT;
        end else if (tick) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DIM: begin
        cnt_d = '0;
        if (!dim_request) state_d = FADE_IN;
      end
      default: state_d = BRIGHT;
    endcase
  end

  // products at full width; >>4 then truncate, so level 16 is unity gain
  always_comb begin
    r_prod = (RW+5)'(s1_rgb_q[PW-1 -: RW])    * (RW+5)'(s1_lvl_q);
    g_prod = (GW+5)'(s1_rgb_q[BW+GW-1 -: GW]) * (GW+5)'(s1_lvl_q);
    b_prod = (BW+5)'(s1_rgb_q[BW-1:0])        * (BW+5)'(s1_lvl_q);
    s1_rgb_d  = s1_rgb_q;
    s1_sync_d = s1_sync_q;
    s1_lvl_d  = s1_lvl_q;
    s2_rgb_d  = s2_rgb_q;
    s2_sync_d = s2_sync_q;
    if (ce_pix) begin
      s1_rgb_d  = vid.rgb_in;
      s1_sync_d = {vid.hs_in, vid.vs_in, vid.hb_in, vid.vb_in};
      s1_lvl_d  = level_q;
      s2_rgb_d  = {RW'(r_prod >> 4), GW'(g_prod >> 4), BW'(b_prod >> 4)};
      s2_sync_d = s1_sync_q;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= BRIGHT;
      level_q   <= 5'd16;
      cnt_q     <= '0;
      vb_prev_q <= 1'b1;
      s1_rgb_q  <= '0;
      s1_sync_q <= '0;
      s1_lvl_q  <= '0;
      s2_rgb_q  <= '0;
      s2_sync_q <= '0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      vb_prev_q <= vb_prev_d;
      s1_rgb_q  <= s1_rgb_d;
      s1_sync_q <= s1_sync_d;
      s1_lvl_q  <= s1_lvl_d;
      s2_rgb_q  <= s2_rgb_d;
      s2_sync_q <= s2_sync_d;
    end
  end

  assign vid.rgb_out = s2_rgb_q;
  assign {vid.hs_out, vid.vs_out, vid.hb_out, vid.vb_out} = s2_sync_q;
  assign level  = level_q;
  assign fading = (state_q == FADE_OUT) || (state_q == FADE_IN);
endmodule

// File: doc/pause_fade.md
PAUSE_FADE -- requirements
Module: pause_fade

Interface
REQ-001 Parameter RW, default 8, width of the red channel.
REQ-002 Parameter GW, default 8, width of the green channel.
REQ-003 Parameter BW, default 8, width of the blue channel.
REQ-004 Parameter STEP_FRAMES, default 4, frames per brightness step; legal range 1..255.
REQ-005 Parameter MIN_LEVEL, default 8, dimmed brightness in sixteenths; legal range 0..15.
REQ-006 clk_sys  in  1  core system clock; the only clock.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 ce_pix  in  1  pixel clock enable; pipeline advances only when high.
REQ-009 dim_request  in  1  dim requested by the pause stage (active-high), synchronous to clk_sys.
REQ-010 rgb_in  in  RW+GW+BW  packed {r,g,b} pixel from the pause stage.
REQ-011 hs_in, vs_in, hb_in, vb_in  in  1 each  hsync, vsync, hblank, vblank paired with rgb_in.
REQ-012 rgb_out  out  RW+GW+BW  packed {r,g,b} pixel to arcade_video.
REQ-013 hs_out, vs_out, hb_out, vb_out  out  1 each  timing signals delayed to match rgb_out.
REQ-014 level  out  5  current brightness, 0..16, where 16 is full.
REQ-015 fading  out  1  high while a fade is in progress.

Function
REQ-016 The block SHALL hold states BRIGHT, FADE_OUT, DIM and FADE_IN.
REQ-017 Target level SHALL be MIN_LEVEL when dim_request=1, else 16.
REQ-018 Frame tick SHALL be a vb_in 0->1 transition detected on a ce_pix cycle; the previous-vb register updates only on ce_pix.
REQ-019 An 8-bit frame counter SHALL increment on each frame tick while in FADE_OUT or FADE_IN.
- When the counter equals STEP_FRAMES-1 on a tick: counter clears; level moves one step toward target, -1 in FADE_OUT, +1 in FADE_IN.
REQ-020 Level SHALL change only on a frame tick, never mid-frame.
REQ-021 Transitions SHALL be:
- BRIGHT->FADE_OUT when dim_request=1.
- FADE_OUT->DIM on the tick where level reaches MIN_LEVEL.
- DIM->FADE_IN when dim_request=0.
- FADE_IN->BRIGHT on the tick where level reaches 16.
REQ-022 Reversal of dim_request mid-fade SHALL switch FADE_OUT<->FADE_IN on the next clk_sys cycle, clear the frame counter and keep the current level.
REQ-023 fading SHALL be 1 exactly in FADE_OUT and FADE_IN.
REQ-024 Each channel output SHALL be (c*level)>>4, computed at the full product width (channel width + 5 bits) and truncated to the channel width.
- level=16 gives c exactly.
- level=0 gives 0.
REQ-025 The pixel path SHALL be a 2-stage pipeline advancing on ce_pix: stage 1 registers the inputs plus level and forms the products; stage 2 registers the outputs.
- Latency is exactly 2 ce_pix cycles.
- hs/vs/hb/vb SHALL pass through the same 2 stages.
REQ-026 The level used for a pixel SHALL be the level sampled into stage 1 with that pixel.
REQ-027 With ce_pix=0, all pipeline registers SHALL hold.
REQ-028 If MIN_LEVEL=16 is forced, dim_request SHALL produce no visible change; the FSM may cycle but level stays 16.

Reset
REQ-029 On reset the block SHALL set:
- state=BRIGHT, level=16, frame counter=0;
- previous-vb register=1, so a high vb_in at reset release is not a tick;
- all pipeline registers, rgb_out and hs/vs/hb/vb_out = 0, fading=0.
REQ-030 Reset asserted mid-fade SHALL take effect on the next clk_sys edge regardless of ce_pix, snapping level to 16.
REQ-031 Reset SHALL take priority over dim_request in the same cycle.

Verification
REQ-032 Defaults, ce_pix=1, dim_request=0, rgb_in=0xFF8040 -> rgb_out=0xFF8040 two cycles later; level=16; fading=0.
REQ-033 Defaults, dim_request=1, 40 vblank rising edges -> level steps 16,15,...,8 every 4 frames, then holds 8; DIM after the 32nd tick; rgb 0xFF8040 -> 0x7F4020.
REQ-034 From DIM, drop dim_request -> FADE_IN; level 9 after 4 ticks; BRIGHT with level=16 after 32 ticks; fading=0.
REQ-035 Mid FADE_OUT at level 12, counter=2, raise then drop dim_request -> FADE_IN next cycle; counter=0; level 13 after exactly 4 further ticks.
REQ-036 Reset asserted mid-fade with vb_in held high -> level=16, outputs 0 next cycle; no tick after release until vb_in falls and rises again.
REQ-037 ce_pix pulsing every 4th cycle with random pixels and syncs -> rgb_out and hs/vs/hb/vb_out exactly 2 ce_pix pulses behind their inputs, held between pulses.
